// File: rtl/mult_job_initiator.sv
// Requesting side of the startMult/endMult handshake: latches one operand job, runs the
// multiplier, then streams the captured result row-major. Optional watchdog: MULT_TIMEOUT_EN.
module mult_job_initiator #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned nos     = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [nos*nos*WIDTH-1:0]     job_A,
  input  logic [nos*nos*WIDTH-1:0]     job_B,
  input  logic [nos*nos*WIDTH-1:0]     job_C,
  output logic [nos*nos*WIDTH-1:0]     A,
  output logic [nos*nos*WIDTH-1:0]     B,
  output logic [nos*nos*WIDTH-1:0]     C,
  output logic                         startMult,
  input  logic                         endMult,
  input  logic [nos*nos*WIDTH-1:0]     Res,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(nos)-1:0]       out_row,
  output logic [$clog2(nos)-1:0]       out_col,
  output logic                         out_last,
  output logic                         busy,
  output logic                         err
);

  localparam int unsigned IW = $clog2(nos);
  localparam logic [IW-1:0] LAST_IDX = IW'(nos - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              start_d, valid_d, last_d, ready_d, busy_d;
  logic [IW-1:0]     row_d, col_d;
  logic [WIDTH-1:0]  data_d;
  logic              accept, capture;

  logic [WIDTH-1:0]  res_mat [nos][nos];
  logic [WIDTH-1:0]  res_buf [nos][nos];

`ifdef MULT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_d;
`endif

  // View the flat result bus as a row-major matrix
  for (genvar gi = 0; gi < nos; gi++) begin : g_row
    for (genvar gj = 0; gj < nos; gj++) begin : g_col
      assign res_mat[gi][gj] = Res[(gi*nos + gj)*WIDTH +: WIDTH];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    start_d = startMult;
    valid_d = out_valid;
    last_d  = out_last;
    ready_d = job_ready;
    busy_d  = busy;
    row_d   = out_row;
    col_d   = out_col;
    data_d  = out_data;
    accept  = 1'b0;
    capture = 1'b0;
`ifdef MULT_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err;
`endif
    case (state_q)
      IDLE: begin
        if (job_valid && job_ready) begin
          accept  = 1'b1;
          state_d = START;
          ready_d = 1'b0;
          busy_d  = 1'b1;
`ifdef MULT_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      START: begin
        // endMult is deliberately not looked at here
        start_d = 1'b1;
        state_d = WAIT;
`ifdef MULT_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (endMult) begin
          capture = 1'b1;
          start_d = 1'b0;
          valid_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
          data_d  = res_mat[0][0];
          last_d  = (nos == 1);
          state_d = DRAIN;
        end
`ifdef MULT_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            if (out_col == LAST_IDX) begin
              col_d = '0;
              row_d = out_row + IW'(1);
            end else begin
              col_d = out_col + IW'(1);
            end
            data_d = res_buf[row_d][col_d];
            last_d = (row_d == LAST_IDX) && (col_d == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      startMult <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      job_ready <= 1'b1;
      busy      <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      startMult <= start_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      job_ready <= ready_d;
      busy      <= busy_d;
      out_row   <= row_d;
      out_col   <= col_d;
      out_data  <= data_d;
    end
  end

  // Operand and result storage; operands change only on job acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      A       <= '0;
      B       <= '0;
      C       <= '0;
      res_buf <= '{default: '0};
    end else begin
      if (accept) begin
        A <= job_A;
        B <= job_B;
        C <= job_C;
      end
      if (capture) res_buf <= res_mat;
    end
  end

`ifdef MULT_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err   <= err_d;
    end
  end
`else
  // Without the watchdog the error flag can never fire
  localparam bit NO_TIMEOUT = (TIMEOUT == 0);
  assign err = NO_TIMEOUT & 1'b0;
`endif

endmodule

// File: tb/tb_mult_job_initiator.sv
// Randomized bench for mult_job_initiator: a queue-based row-major model of the result
// stream plus a behavioural multiplier that answers startMult after a chosen latency.
module tb_mult_job_initiator;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NOS   = 4;
  localparam int unsigned N     = NOS * NOS;
  localparam int unsigned MW    = N * WIDTH;
`ifdef MULT_TIMEOUT_EN
  localparam int unsigned TMO    = 8;
  localparam int unsigned MAXLAT = 5;
`else
  localparam int unsigned TMO    = 1024;
  localparam int unsigned MAXLAT = 12;
`endif

  logic              clk, rst;
  logic              job_valid, job_ready;
  logic [MW-1:0]     job_A, job_B, job_C, A, B, C, Res;
  logic              startMult, endMult;
  logic              out_valid, out_ready, out_last, busy, err;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        out_row, out_col;

  int n_cmp = 0;
  int n_mis = 0;

  mult_job_initiator #(.WIDTH(WIDTH), .nos(NOS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_A(job_A), .job_B(job_B), .job_C(job_C),
    .A(A), .B(B), .C(C),
    .startMult(startMult), .endMult(endMult), .Res(Res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < int'(N); i++) m[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return m;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_job_ready"}, job_ready, 1);
    check({tag, "_startMult"}, startMult, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_err"},       err, 0);
    check({tag, "_A"},         A, 0);
  endtask

  // bp: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  task automatic run_job(input logic [MW-1:0] ja, input logic [MW-1:0] jb,
                         input logic [MW-1:0] jc, input logic [MW-1:0] res,
                         input int lat, input bit early, input int bp,
                         input bit rst_wait, input int rst_beat);
    logic [WIDTH-1:0] exp_q [$];
    int waited, beat, cyc;
    logic rdy;
    waited = 0;
    while (!job_ready && waited < 50) begin
      step();
      waited++;
    end
    check("job_ready_idle", job_ready, 1);
    job_A = ja; job_B = jb; job_C = jc; job_valid = 1'b1;
    step();
    check("accept_busy", busy, 1);
    check("accept_job_ready", job_ready, 0);
    check("accept_no_start", startMult, 0);
    check("accept_err_clear", err, 0);
    check("latch_A", A, ja);
    check("latch_B", B, jb);
    check("latch_C", C, jc);
    // job_valid stays high with different data; it must be ignored until IDLE
    job_A = ~ja; job_B = ~jb; job_C = ~jc;
    if (early) endMult = 1'b1;
    step();
    endMult = 1'b0;
    check("start_rise", startMult, 1);
    check("hold_A", A, ja);
    if (rst_wait) begin
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      job_valid = 1'b0;
      check_reset_state("rst_wait");
      return;
    end
    for (int k = 0; k < lat; k++) begin
      step();
      check("wait_start", startMult, 1);
      check("wait_no_valid", out_valid, 0);
    end
    check("wait_hold_C", C, jc);
    Res = res;
    endMult = 1'b1;
    step();
    endMult = 1'b0;
    Res = rand_mat();
    check("end_drop", startMult, 0);
    for (int i = 0; i < int'(N); i++) exp_q.push_back(res[i*WIDTH +: WIDTH]);
    beat = 0;
    cyc = 0;
    while (beat < int'(N) && cyc < 400) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, exp_q[beat]);
      check("drain_row", out_row, beat / NOS);
      check("drain_col", out_col, beat % NOS);
      check("drain_last", out_last, beat == int'(N) - 1);
      if (beat == rst_beat) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        job_valid = 1'b0;
        check_reset_state("rst_drain");
        return;
      end
      case (bp)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      step();
      if (rdy) beat++;
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", beat, N);
    check("post_valid", out_valid, 0);
    check("post_job_ready", job_ready, 1);
    check("post_busy", busy, 0);
    job_valid = 1'b0;
    step();
    check("no_reaccept", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] ja, res_fixed;
    int av [16] = '{7, 3, 9, 6, 1, 6, 5, 2, 2, 4, 3, 3, 3, 5, 5, 7};
    int hi;

    rst = 1'b1; job_valid = 1'b1; endMult = 1'b0; out_ready = 1'b0;
    job_A = rand_mat(); job_B = rand_mat(); job_C = rand_mat(); Res = rand_mat();
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");
    job_valid = 1'b0;

    for (int i = 0; i < int'(N); i++) begin
      ja[i*WIDTH +: WIDTH]        = WIDTH'(av[i]);
      res_fixed[i*WIDTH +: WIDTH] = WIDTH'(16 * (i / NOS) + (i % NOS));
    end
    run_job(ja, rand_mat(), rand_mat(), res_fixed, (MAXLAT < 10) ? MAXLAT : 10, 0, 0, 0, -1);

    run_job(rand_mat(), rand_mat(), rand_mat(), rand_mat(), 3, 0, 1, 0, -1);
    run_job(rand_mat(), rand_mat(), rand_mat(), rand_mat(), 4, 1, 2, 0, -1);

    run_job(rand_mat(), rand_mat(), rand_mat(), rand_mat(), 4, 0, 0, 1, -1);
    run_job(rand_mat(), rand_mat(), rand_mat(), rand_mat(), 2, 0, 0, 0, -1);
    run_job(rand_mat(), rand_mat(), rand_mat(), rand_mat(), 2, 0, 1, 0, 5);
    run_job(rand_mat(), rand_mat(), rand_mat(), rand_mat(), 1, 0, 0, 0, -1);

    for (int t = 0; t < 6; t++)
      run_job(rand_mat(), rand_mat(), rand_mat(), rand_mat(),
              int'($urandom_range(0, MAXLAT)), 1'($urandom_range(0, 1)), 2, 0, -1);

`ifdef MULT_TIMEOUT_EN
    job_A = rand_mat(); job_B = rand_mat(); job_C = rand_mat();
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    check("tmo_busy", busy, 1);
    step();
    check("tmo_start", startMult, 1);
    hi = 1;
    while (startMult && hi < 50) begin
      step();
      if (startMult) hi++;
      check("tmo_no_valid", out_valid, 0);
    end
    check("tmo_cycles", hi, TMO);
    check("tmo_err", err, 1);
    check("tmo_job_ready", job_ready, 1);
    check("tmo_busy_low", busy, 0);
    repeat (3) step();
    check("tmo_err_sticky", err, 1);
    check("tmo_still_no_valid", out_valid, 0);
    run_job(rand_mat(), rand_mat(), rand_mat(), rand_mat(), 3, 0, 2, 0, -1);
`else
    hi = 0;
    check("no_tmo_err", err, hi);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mult_job_initiator.md
Name: mult_job_initiator

Overview:
- Initiator (requesting) end of the startMult/endMult handshake used by the three-matrix multiplier in the Kalman filter datapath.
- Accepts one job from upstream: three nos×nos operand matrices.
- Registers the operands and holds them stable on its operand outputs, then drives startMult and waits for endMult.
- Captures Res, then streams the result to the downstream consumer one element per beat, row-major, over a valid/ready interface.

Parameters:
WIDTH, 16, bit width of every matrix element
nos, 4, matrix dimension (number of states); matrices are nos×nos
TIMEOUT, 1024, max cycles in WAIT before abort (used only when MULT_TIMEOUT_EN is defined)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
job_valid  in  1  upstream has a job on job_A/B/C
job_ready  out  1  block can accept a job (high only in IDLE)
job_A, job_B, job_C  in  WIDTH × [nos][nos]  upstream operand matrices
A, B, C  out  WIDTH × [nos][nos]  registered operands to multiplier
startMult  out  1  request to multiplier
endMult  in  1  multiplier completion
Res  in  WIDTH × [nos][nos]  multiplier result, valid while endMult high
out_valid  out  1  result element valid
out_ready  in  1  downstream accepts element
out_data  out  WIDTH  element Res[out_row][out_col] as captured
out_row, out_col  out  $clog2(nos)  element indices
out_last  out  1  high with the final element (nos-1, nos-1)
busy  out  1  high in any state except IDLE
err  out  1  timeout sticky flag (MULT_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset (rst sampled high at clk edge):
  - State to IDLE.
  - startMult, out_valid, out_last, busy, err = 0; job_ready = 1 after reset.
  - A/B/C, result buffer and indices cleared to 0.
  - Reset mid-job aborts immediately; no partial output.
- FSM states: IDLE, START, WAIT, DRAIN.
- IDLE:
  - job_ready = 1.
  - On job_valid && job_ready: latch job_A/B/C into A/B/C, go to START next cycle.
  - A/B/C change only at this acceptance.
- START:
  - startMult = 1 (registered), then go to WAIT.
  - A/B/C are stable at least one cycle before startMult rises.
- WAIT:
  - startMult held at 1 until endMult is sampled high.
  - On the cycle endMult is sampled high: capture all nos×nos Res entries into the result buffer and deassert startMult on the next edge.
  - Set out_row = out_col = 0, go to DRAIN.
  - endMult asserted in START is ignored; only WAIT samples it.
- DRAIN:
  - out_valid = 1; out_data = buffer[out_row][out_col].
  - On out_valid && out_ready: advance out_col. When out_col == nos-1, wrap out_col to 0 and increment out_row.
  - out_last = 1 when out_row == out_col == nos-1.
  - Accepted beat with out_last: clear out_valid and return to IDLE next cycle. job_ready is high that cycle; no back-to-back overlap.
  - out_ready low: hold data, indices and out_valid (AXI-style; no valid drop).
- Latency:
  - Job accept → startMult high: 1 cycle.
  - endMult sampled → first out_valid: 1 cycle.
  - Full drain with out_ready held high: nos*nos cycles.
- Arithmetic: no arithmetic on data; values are passed through bit-exact. Index counters are $clog2(nos) bits and never exceed nos-1.
- job_valid while busy: ignored; job_ready = 0.

Optional Feature:
MULT_TIMEOUT_EN:
- Defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles elapse without endMult: deassert startMult, set err = 1 (sticky until rst or next accepted job), return to IDLE, produce no output beats.
  - endMult arriving on the exact timeout cycle counts as success.
- Undefined: no counter; WAIT waits indefinitely; err is constant 0.

Test Plan:
- Reset: rst high 2 cycles with job_valid = 1 → job_ready = 1, startMult = 0, out_valid = 0, busy = 0 after release.
- Basic job:
  - Stimulus: job_A rows {7,3,9,6},{1,6,5,2},{2,4,3,3},{3,5,5,7}; a model multiplier asserts endMult 10 cycles after startMult with Res[i][j] = 16*i+j; out_ready tied 1.
  - Response: A equals job_A while startMult is high; 16 beats with out_data 0..3,16..19,32..35,48..51; out_last only on the 16th beat; then IDLE.
- Backpressure: toggle out_ready 1,0,0,1,… during DRAIN → no skipped or duplicated element; out_data/out_row/out_col stable while stalled.
- Early endMult / busy job:
  - endMult pulsed in the START cycle → ignored, still waits for the WAIT-phase endMult.
  - job_valid held high in DRAIN → no second accept until IDLE.
- Reset mid-job: rst in WAIT and again at beat 5 of DRAIN → outputs return to reset values next edge; a fresh job then completes normally.
- MULT_TIMEOUT_EN, TIMEOUT = 8, endMult never asserted → startMult drops after 8 WAIT cycles, err = 1, no out_valid; next accepted job clears err.
